rv32im_writeback: RTL and testbench

- Write-side companion of the CPU register file.
- Collects results from the ALU, load unit and multi-cycle mul/div unit, and arbitrates them onto the single register-file write port.
- Aligns and sign-extends load data.
- Keeps a per-register pending scoreboard so decode can stall on read-after-write hazards. Sits between the execute/memory units and the register-file write port.

---
 rtl/rv32im_pkg.sv | 17 +
 rtl/rv32im_load_align.sv | 28 ++
 rtl/rv32im_writeback.sv | 153 +++++++++++++++
 tb/tb_rv32im_writeback.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// rtl/rv32im_pkg.sv - shared load encodings and writeback source select for rv32im_writeback
package rv32im_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_ALU,
    SRC_MD
  } src_e;

endpackage

// File: rtl/rv32im_load_align.sv
// rtl/rv32im_load_align.sv - byte/halfword extraction and sign/zero extension of load data
module rv32im_load_align #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);
  import rv32im_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = word_i[{off_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      // LW and all undefined encodings pass the raw word through
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/rv32im_writeback.sv
// rtl/rv32im_writeback.sv - load/ALU/mul-div writeback arbiter with per-register pending scoreboard
// Optional register-file bypass outputs are enabled by defining WB_FORWARD_EN.
module rv32im_writeback #(
  parameter int XLEN      = 32,
  parameter int REG_BITS  = 5,
  parameter int PEND_BITS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic [REG_BITS-1:0] issue_rd_i,
  output logic                issue_ready_o,
  input  logic [REG_BITS-1:0] rs1_addr_i,
  input  logic [REG_BITS-1:0] rs2_addr_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  input  logic                load_valid_i,
  input  logic [REG_BITS-1:0] load_rd_i,
  input  logic [2:0]          load_funct3_i,
  input  logic [1:0]          load_off_i,
  input  logic [XLEN-1:0]     load_word_i,
  input  logic                alu_valid_i,
  input  logic [REG_BITS-1:0] alu_rd_i,
  input  logic [XLEN-1:0]     alu_data_i,
  output logic                alu_ready_o,
  input  logic                md_valid_i,
  input  logic [REG_BITS-1:0] md_rd_i,
  input  logic [XLEN-1:0]     md_data_i,
  output logic                md_ready_o,
  output logic                write_o,
  output logic [REG_BITS-1:0] rd_addr_o,
  output logic [XLEN-1:0]     data_o
`ifdef WB_FORWARD_EN
  ,
  output logic                fwd_rs1_o,
  output logic                fwd_rs2_o,
  output logic [XLEN-1:0]     fwd_data_o
`endif
);
  import rv32im_pkg::*;

  localparam int NREGS = 2 ** REG_BITS;
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;
  localparam logic [PEND_BITS-1:0] PEND_ONE = PEND_BITS'(1);

  src_e                src_sel;
  logic [REG_BITS-1:0] sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic [XLEN-1:0]     load_data;

  logic                write_q, write_d;
  logic [REG_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     data_q, data_d;

  logic [PEND_BITS-1:0] pend_q [NREGS];
  logic [PEND_BITS-1:0] pend_d [NREGS];
  logic [NREGS-1:0]     inc_vec;
  logic [NREGS-1:0]     dec_vec;
  logic                 issue_inc;
  logic [PEND_BITS-1:0] rs1_cnt, rs2_cnt;

  rv32im_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i (load_funct3_i),
    .off_i    (load_off_i),
    .word_i   (load_word_i),
    .data_o   (load_data)
  );

  assign alu_ready_o = alu_valid_i & ~load_valid_i;
  assign md_ready_o  = md_valid_i & ~load_valid_i & ~alu_valid_i;

  always_comb begin
    src_sel  = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (load_valid_i) begin
      src_sel  = SRC_LOAD;
      sel_rd   = load_rd_i;
      sel_data = load_data;
    end else if (alu_valid_i) begin
      src_sel  = SRC_ALU;
      sel_rd   = alu_rd_i;
      sel_data = alu_data_i;
    end else if (md_valid_i) begin
      src_sel  = SRC_MD;
      sel_rd   = md_rd_i;
      sel_data = md_data_i;
    end
    // x0 results are consumed but never reach the register file
    write_d   = (src_sel != SRC_NONE) && (sel_rd != '0);
    rd_addr_d = write_d ? sel_rd : rd_addr_q;
    data_d    = write_d ? sel_data : data_q;
  end

  assign issue_ready_o = pend_q[issue_rd_i] != PEND_MAX;
  assign issue_inc     = issue_valid_i & issue_ready_o & (issue_rd_i != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_inc) inc_vec[issue_rd_i] = 1'b1;
    if (write_q)   dec_vec[rd_addr_q]  = 1'b1;
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (dec_vec[r] && !inc_vec[r] && (pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q   <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= '0;
      for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
    end else begin
      write_q   <= write_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
    end
  end

  assign write_o   = write_q;
  assign rd_addr_o = rd_addr_q;
  assign data_o    = data_q;

  assign rs1_cnt = pend_q[rs1_addr_i];
  assign rs2_cnt = pend_q[rs2_addr_i];

`ifdef WB_FORWARD_EN
  assign fwd_rs1_o  = write_q & (rd_addr_q != '0) & (rd_addr_q == rs1_addr_i);
  assign fwd_rs2_o  = write_q & (rd_addr_q != '0) & (rd_addr_q == rs2_addr_i);
  assign fwd_data_o = data_q;
  // The last outstanding write is on the bypass path, so decode need not wait
  assign rs1_busy_o = (rs1_cnt != '0) & ~(fwd_rs1_o & (rs1_cnt == PEND_ONE));
  assign rs2_busy_o = (rs2_cnt != '0) & ~(fwd_rs2_o & (rs2_cnt == PEND_ONE));
`else
  assign rs1_busy_o = rs1_cnt != '0;
  assign rs2_busy_o = rs2_cnt != '0;
`endif

  pend_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    write_q |-> (pend_q[rd_addr_q] != '0));

endmodule

// File: tb/tb_rv32im_writeback.sv
// tb/tb_rv32im_writeback.sv - scoreboard bench for rv32im_writeback with directed and random traffic
module tb_rv32im_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [2:0]  load_f3;
  logic [1:0]  load_off;
  logic [31:0] load_word;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid, md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        write_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] data_o;

  always #5 clk = ~clk;

  rv32im_writeback dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .load_valid_i(load_valid), .load_rd_i(load_rd), .load_funct3_i(load_f3),
    .load_off_i(load_off), .load_word_i(load_word),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .md_valid_i(md_valid), .md_rd_i(md_rd), .md_data_i(md_data), .md_ready_o(md_ready),
    .write_o(write_o), .rd_addr_o(rd_addr_o), .data_o(data_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         m_cnt[32];
  int         cyc = 0;
  bit         m_infl = 0;
  logic [4:0] m_infl_rd = '0;
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endfunction

  function automatic void chk1(string name, logic got, logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (int'(off) * 8)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (int'(off[1]) * 16)) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Reference model: pending counts and expected register-file writes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      exp_q.delete();
      m_infl = 0;
    end else begin
      bit         inc_ok, acc;
      logic [4:0]  rd;
      logic [31:0] d;
      cyc++;
      inc_ok = issue_valid && issue_rd != 0 && m_cnt[issue_rd] != 3;
      if (m_infl) m_cnt[m_infl_rd] = m_cnt[m_infl_rd] - 1;
      if (inc_ok) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
      acc = 1; rd = '0; d = '0;
      if (load_valid) begin rd = load_rd; d = ref_load(load_f3, load_off, load_word); end
      else if (alu_valid) begin rd = alu_rd; d = alu_data; end
      else if (md_valid) begin rd = md_rd; d = md_data; end
      else acc = 0;
      m_infl = acc && rd != 0;
      m_infl_rd = rd;
      if (m_infl) exp_q.push_back('{rd: rd, data: d, cyc: cyc});
    end
  end

  // Monitor: every write strobe must match the oldest expected write, in its cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (write_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", rd_addr_o, data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_rd", 32'(rd_addr_o), 32'(e.rd));
          chk("wb_data", data_o, e.data);
          chk("wb_cycle", cyc, e.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        $display("FAIL missing_write: got no write expected rd=%0d data=%h", e.rd, e.data);
      end
    end
  end

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd = rd;
    #1 chk1("issue_ready", issue_ready, m_cnt[rd] != 3);
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic load1(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] w);
    load_valid = 1'b1; load_rd = rd; load_f3 = f3; load_off = off; load_word = w;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic alu1(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    @(negedge clk);
    alu_valid = 1'b0;
  endtask

  logic [4:0] owed[$];
  bit         alu_acc, md_acc, drained;

  initial begin
    rst = 1'b1;
    issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    load_valid = 0; load_rd = 0; load_f3 = 0; load_off = 0; load_word = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    repeat (3) @(negedge clk);
    chk1("rst_write", write_o, 1'b0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk1("rst_rs1_busy", rs1_busy, 1'b0);
    chk1("rst_rs2_busy", rs2_busy, 1'b0);
    chk1("rst_issue_ready", issue_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Load alignment
    issue(5'd4); issue(5'd4); issue(5'd4);
    load1(5'd4, 3'b000, 2'd3, 32'h80FF_1234);
    chk1("lb_write", write_o, 1'b1);
    chk("lb_data", data_o, 32'hFFFF_FF80);
    load1(5'd4, 3'b100, 2'd3, 32'h80FF_1234);
    chk("lbu_data", data_o, 32'h0000_0080);
    load1(5'd4, 3'b001, 2'd2, 32'h80FF_1234);
    chk("lh_data", data_o, 32'hFFFF_80FF);
    @(negedge clk);

    // Priority: load > ALU > mul/div
    issue(5'd5); issue(5'd6); issue(5'd7);
    load_valid = 1; load_rd = 5'd5; load_f3 = 3'b010; load_off = 2'd1; load_word = $urandom;
    alu_valid = 1; alu_rd = 5'd6; alu_data = $urandom;
    md_valid = 1; md_rd = 5'd7; md_data = $urandom;
    #1 chk1("prio_alu_ready0", alu_ready, 1'b0);
    chk1("prio_md_ready0", md_ready, 1'b0);
    @(negedge clk); load_valid = 0;
    chk("prio_first_rd", 32'(rd_addr_o), 32'd5);
    #1 chk1("prio_alu_ready1", alu_ready, 1'b1);
    chk1("prio_md_ready1", md_ready, 1'b0);
    @(negedge clk); alu_valid = 0;
    chk("prio_second_rd", 32'(rd_addr_o), 32'd6);
    #1 chk1("prio_md_ready2", md_ready, 1'b1);
    @(negedge clk); md_valid = 0;
    chk("prio_third_rd", 32'(rd_addr_o), 32'd7);
    @(negedge clk);

    // Busy through two outstanding writes
    issue(5'd3); issue(5'd3);
    rs1_addr = 5'd3;
    #1 chk1("busy_x3_issued", rs1_busy, 1'b1);
    alu1(5'd3, 32'h1111_0003);
    chk1("busy_x3_first_write", rs1_busy, 1'b1);
    alu1(5'd3, 32'h2222_0003);
    chk1("busy_x3_second_write", rs1_busy, 1'b1);
    @(negedge clk);
    chk1("busy_x3_cleared", rs1_busy, 1'b0);

    // Counter saturation
    issue(5'd9); issue(5'd9); issue(5'd9);
    issue_rd = 5'd9; rs1_addr = 5'd9;
    #1 chk1("sat_ready", issue_ready, 1'b0);
    issue(5'd9);
    #1 chk1("sat_still_busy", rs1_busy, 1'b1);
    chk1("sat_still_not_ready", issue_ready, 1'b0);
    alu1(5'd9, 32'hA); alu1(5'd9, 32'hB); alu1(5'd9, 32'hC);
    chk1("sat_busy_last_write", rs1_busy, 1'b1);
    @(negedge clk);
    chk1("sat_drained", rs1_busy, 1'b0);

    // x0 results
    issue(5'd0);
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF; rs1_addr = 5'd0;
    #1 chk1("x0_alu_ready", alu_ready, 1'b1);
    @(negedge clk); alu_valid = 0;
    chk1("x0_no_write", write_o, 1'b0);
    chk1("x0_not_busy", rs1_busy, 1'b0);
    @(negedge clk);

    // Reset in the middle of a writeback
    issue(5'd12); issue(5'd12);
    alu1(5'd12, 32'h0C0C_0C0C);
    rs1_addr = 5'd12; rs2_addr = 5'd12;
    chk1("mid_rst_write_before", write_o, 1'b1);
    #2 rst = 1'b1;
    #1 chk1("mid_rst_write", write_o, 1'b0);
    chk1("mid_rst_rs1_busy", rs1_busy, 1'b0);
    chk1("mid_rst_rs2_busy", rs2_busy, 1'b0);
    chk("mid_rst_data", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic
    drained = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c >= 500 && owed.size() == 0 && !alu_valid && !md_valid) begin
        drained = 1;
        break;
      end
      if (!alu_valid && owed.size() > 0 && $urandom_range(0, 2) == 0) begin
        alu_valid = 1; alu_rd = owed.pop_front(); alu_data = $urandom;
      end else if (!alu_valid && $urandom_range(0, 19) == 0) begin
        alu_valid = 1; alu_rd = 5'd0; alu_data = $urandom;
      end
      if (!md_valid && owed.size() > 0 && $urandom_range(0, 3) == 0) begin
        md_valid = 1; md_rd = owed.pop_front(); md_data = $urandom;
      end
      if (owed.size() > 0 && $urandom_range(0, 3) == 0) begin
        load_valid = 1; load_rd = owed.pop_front();
        load_f3 = 3'($urandom_range(0, 7)); load_off = 2'($urandom_range(0, 3));
        load_word = $urandom;
      end else begin
        load_valid = 0;
      end
      issue_valid = (c < 500) && ($urandom_range(0, 1) == 1);
      issue_rd = 5'($urandom_range(0, 7));
      if (issue_valid && issue_rd != 0 && m_cnt[issue_rd] != 3) owed.push_back(issue_rd);
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      #1;
      chk1("rnd_issue_ready", issue_ready, m_cnt[issue_rd] != 3);
      chk1("rnd_rs1_busy", rs1_busy, m_cnt[rs1_addr] != 0);
      chk1("rnd_rs2_busy", rs2_busy, m_cnt[rs2_addr] != 0);
      chk1("rnd_alu_ready", alu_ready, alu_valid && !load_valid);
      chk1("rnd_md_ready", md_ready, md_valid && !load_valid && !alu_valid);
      alu_acc = alu_valid && !load_valid;
      md_acc = md_valid && !load_valid && !alu_valid;
      @(negedge clk);
      if (alu_acc) alu_valid = 0;
      if (md_acc) md_valid = 0;
    end
    if (!drained) begin
      n_checks++;
      $display("FAIL drain_timeout: got outstanding=%0d expected 0", owed.size());
    end
    issue_valid = 0; load_valid = 0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r);
      issue_rd = 5'(r);
      #1 chk1("final_busy", rs1_busy, 1'b0);
      chk1("final_issue_ready", issue_ready, 1'b1);
    end
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
